// File: rtl/ioctl_upload_pkg.sv
// Shared types and helpers for the ioctl upload (SDRAM read-back) path.
package ioctl_upload_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      FETCH
   } state_t;

   localparam logic [7:0] UPLOAD_INDEX_DEFAULT = 8'd4;

   // addr[0]=0 selects the low byte, matching the download wrl/wrh mapping
   function automatic logic [7:0] byte_lane(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sdr_toggle_port.sv
// Toggle-style SDRAM request port: owns req/ack handshake, word address and completion.
module sdr_toggle_port #(
   parameter int AW = 24
)(
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          align,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic          sdr_ack,
   output logic          sdr_req,
   output logic [AW-1:0] sdr_addr,
   output logic          done,
   output logic          busy
);

   assign done = busy & (sdr_ack == sdr_req);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sdr_req  <= 1'b0;
         sdr_addr <= '0;
         busy     <= 1'b0;
      end else if (align) begin
         // Abandon any outstanding request by making req equal ack again
         sdr_req <= sdr_ack;
         busy    <= 1'b0;
      end else if (start) begin
         sdr_addr <= start_addr;
         sdr_req  <= ~sdr_req;
         busy     <= 1'b1;
      end else if (done) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ioctl_sdram_upload.sv
// Serves HPS ioctl upload byte reads from SDRAM through a one-word cache.
// Optional fetch timeout with sticky err flag: define UPLOAD_TIMEOUT_EN.
module ioctl_sdram_upload
   import ioctl_upload_pkg::*;
#(
   parameter logic [7:0]  UPLOAD_INDEX   = UPLOAD_INDEX_DEFAULT,
   parameter logic [23:0] SDR_BASE       = 24'h0,
   parameter int          TIMEOUT_CYCLES = 1024
)(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic [23:0] sdr_addr,
   output logic        sdr_req,
   input  logic        sdr_ack,
   input  logic [15:0] sdr_dout,
   output logic        busy,
   output logic        err
);

   state_t      state;
   logic        upload_q;
   logic        cache_valid;
   logic [23:0] cache_tag;
   logic [15:0] cache_word;
   logic [23:0] rd_tag;
   logic        rd_lane;
   logic        discard;

   logic [23:0] rd_word;
   logic        rd_ok, hit, upload_rise;
   logic        port_start, port_align, port_done, timeout;

   assign rd_word     = ioctl_addr[24:1];
   assign rd_ok       = ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX);
   assign upload_rise = ioctl_upload & ~upload_q;
   assign hit         = cache_valid & ~upload_rise & (cache_tag == rd_word);
   assign port_start  = (state == IDLE) & rd_ok & ~hit;
   assign port_align  = (state == SYNC) | timeout;

   sdr_toggle_port #(.AW(24)) u_port (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .align      (port_align),
      .start      (port_start),
      .start_addr (rd_word + SDR_BASE),
      .sdr_ack    (sdr_ack),
      .sdr_req    (sdr_req),
      .sdr_addr   (sdr_addr),
      .done       (port_done),
      .busy       (busy)
   );

   // A fetch in flight is exactly the time the HPS must be stalled
   assign ioctl_wait = busy;

`ifdef UPLOAD_TIMEOUT_EN
   localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;

   assign timeout = (state == FETCH) & ~port_done & (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (port_start)
            tmo_cnt <= '0;
         else if (state == FETCH)
            tmo_cnt <= tmo_cnt + TW'(1);
         if (timeout)
            err <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout            = 1'b0;
   assign err                = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= SYNC;
         ioctl_din   <= 8'h00;
         upload_q    <= 1'b0;
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_word  <= '0;
         rd_tag      <= '0;
         rd_lane     <= 1'b0;
         discard     <= 1'b0;
      end else begin
         upload_q <= ioctl_upload;
         if (upload_rise)
            cache_valid <= 1'b0;

         case (state)
            SYNC: state <= IDLE;

            IDLE: begin
               if (rd_ok) begin
                  if (hit) begin
                     ioctl_din <= byte_lane(cache_word, ioctl_addr[0]);
                  end else begin
                     rd_tag      <= rd_word;
                     rd_lane     <= ioctl_addr[0];
                     discard     <= 1'b0;
                     cache_valid <= 1'b0;
                     state       <= FETCH;
                  end
               end
            end

            FETCH: begin
               // The handshake cannot be cancelled, so an aborted upload only drops the data
               if (!ioctl_upload)
                  discard <= 1'b1;
               if (port_done) begin
                  state <= IDLE;
                  if (!discard && ioctl_upload) begin
                     cache_valid <= 1'b1;
                     cache_tag   <= rd_tag;
                     cache_word  <= sdr_dout;
                     ioctl_din   <= byte_lane(sdr_dout, rd_lane);
                  end
               end else if (timeout) begin
                  ioctl_din <= 8'hFF;
                  state     <= IDLE;
               end
            end

            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_sdram_upload.sv
// Scoreboard bench for ioctl_sdram_upload: random reads against a word-cache reference model.
module tb_ioctl_sdram_upload;

   localparam logic [23:0] BASE = 24'h100000;
   localparam int          TMO  = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = 8'd4;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic        sdr_ack = 1'b0;
   logic [15:0] sdr_dout = '0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [23:0] sdr_addr;
   logic        sdr_req;
   logic        busy;
   logic        err;

   ioctl_sdram_upload #(
      .UPLOAD_INDEX   (8'd4),
      .SDR_BASE       (BASE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .sdr_addr     (sdr_addr),
      .sdr_req      (sdr_req),
      .sdr_ack      (sdr_ack),
      .sdr_dout     (sdr_dout),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0]  din;
      int          waits;
      logic        miss;
      logic [23:0] saddr;
      logic        req_after;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] mem [logic [23:0]];

   // Reference model: the last word successfully fetched during this upload
   bit          m_valid = 1'b0;
   logic [23:0] m_tag = '0;
   logic [15:0] m_word = '0;
   logic [7:0]  m_din = '0;

   int resp_delay = 2;
   bit resp_enable = 1'b1;
   int late_ack_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] get_word(input logic [23:0] sa);
      if (!mem.exists(sa))
         mem[sa] = 16'($urandom);
      return mem[sa];
   endfunction

   function automatic exp_t model_read(input logic [24:0] a, input bit discard,
                                       input bit timeout, input logic req_now);
      exp_t        e;
      logic [23:0] wa;
      logic [15:0] w;
      wa      = a[24:1];
      e.saddr = wa + BASE;
      if (m_valid && m_tag == wa) begin
         e.miss  = 1'b0;
         e.waits = 0;
         e.din   = 8'(m_word >> (a[0] ? 8 : 0));
      end else begin
         e.miss  = 1'b1;
         m_valid = 1'b0;
         if (timeout) begin
            e.waits = TMO;
            e.din   = 8'hFF;
         end else begin
            w       = get_word(e.saddr);
            e.waits = resp_delay + 1;
            if (discard) begin
               e.din = m_din;
            end else begin
               e.din   = 8'(w >> (a[0] ? 8 : 0));
               m_valid = 1'b1;
               m_tag   = wa;
               m_word  = w;
            end
         end
      end
      e.req_after = (e.miss && !timeout) ? ~req_now : req_now;
      m_din = e.din;
      return e;
   endfunction

   // Accepted read; drop_after >= 0 lowers ioctl_upload that many cycles into the fetch
   task automatic do_read(input logic [24:0] a, input int drop_after = -1, input bit timeout = 1'b0);
      exp_t e;
      @(negedge clk_sys);
      e = model_read(a, drop_after >= 0, timeout, sdr_req);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      exp_q.push_back(e);
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      for (int n = 0; n < 300 && exp_q.size() > 0; n++) begin
         if (n == drop_after)
            ioctl_upload = 1'b0;
         @(negedge clk_sys);
      end
      check("read_completed", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Strobes that must be ignored (wrong index or upload inactive)
   task automatic idle_strobes(input logic [7:0] idx, input logic up);
      @(negedge clk_sys);
      ioctl_index  = idx;
      ioctl_upload = up;
      repeat (3) begin
         ioctl_addr = 25'($urandom);
         ioctl_rd   = 1'b1;
         @(negedge clk_sys);
         ioctl_rd = 1'b0;
         @(negedge clk_sys);
      end
      check("idle_req", sdr_req, sdr_ack);
      check("idle_wait", ioctl_wait, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_din", ioctl_din, m_din);
      ioctl_index = 8'd4;
      if (!up)
         m_valid = 1'b0;
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
   endtask

   // SDRAM responder: ack lands resp_delay falling edges after the req toggle is seen
   initial begin
      int seen;
      seen = 0;
      forever begin
         @(negedge clk_sys);
         if (late_ack_cnt != seen) begin
            sdr_ack = ~sdr_ack;
            seen++;
         end else if (resp_enable && reset_n && sdr_req !== sdr_ack) begin
            repeat (resp_delay) @(negedge clk_sys);
            sdr_dout = mem.exists(sdr_addr) ? mem[sdr_addr] : 16'h0000;
            sdr_ack  = sdr_req;
         end
      end
   end

   // Monitor: times the stall of each accepted read and checks what it returned
   initial begin
      exp_t e;
      int   cnt;
      forever begin
         @(posedge clk_sys);
         if (exp_q.size() > 0) begin
            e   = exp_q[0];
            cnt = 0;
            @(negedge clk_sys);
            while (ioctl_wait === 1'b1 && cnt < 100) begin
               @(negedge clk_sys);
               cnt++;
            end
            check("wait_cycles", cnt, e.waits);
            check("din", ioctl_din, e.din);
            check("busy_after", busy, 1'b0);
            check("req_after", sdr_req, e.req_after);
            if (e.miss)
               check("sdr_addr", sdr_addr, e.saddr);
            if (exp_q.size() > 0)
               void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] a;
      int          r;

      repeat (3) @(negedge clk_sys);
      check("rst_din", ioctl_din, 8'h00);
      check("rst_wait", ioctl_wait, 1'b0);
      check("rst_req", sdr_req, 1'b0);
      check("rst_addr", sdr_addr, 24'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);

      // BEEF word: low byte from SDRAM, high byte from cache
      mem[BASE + 24'h10] = 16'hBEEF;
      resp_delay = 3;
      do_read(25'h20);
      check("beef_lo", ioctl_din, 8'hEF);
      do_read(25'h21);
      check("beef_hi", ioctl_din, 8'hBE);

      // Base offset and 7-cycle ack (8-cycle stall checked by monitor)
      resp_delay = 7;
      do_read(25'h4);
      check("base_addr", sdr_addr, 24'h100002);

      idle_strobes(8'd0, 1'b1);
      idle_strobes(8'd4, 1'b0);

      // Random reads over a small window so both hits and misses occur
      for (int i = 0; i < 40; i++) begin
         resp_delay = $urandom_range(0, 6);
         r = $urandom_range(0, 11);
         if (r == 0) begin
            a = 25'h1FFFFFF - 25'($urandom_range(0, 1));
            do_read(a);
         end else if (r == 1) begin
            idle_strobes(8'($urandom_range(5, 255)), 1'b1);
         end else begin
            a = 25'($urandom_range(0, 15));
            do_read(a);
         end
      end

      // Upload aborted mid-fetch: data discarded, next upload re-fetches
      resp_delay = 3;
      do_read(25'h20);
      do_read(25'h30, 1);
      @(negedge clk_sys);
      ioctl_upload = 1'b1;
      m_valid = 1'b0;
      repeat (2) @(negedge clk_sys);
      do_read(25'h21);
      do_read(25'h20);

      // Upload rising edge alone invalidates the cache
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      ioctl_upload = 1'b1;
      m_valid = 1'b0;
      repeat (2) @(negedge clk_sys);
      do_read(25'h20);

      // Reset during a fetch with sdr_ack high
      if (sdr_ack == 1'b0)
         do_read({m_tag + 24'd1, 1'b0});
      resp_enable = 1'b0;
      @(negedge clk_sys);
      ioctl_addr = {m_tag + 24'd2, 1'b0};
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("fetch_busy", busy, 1'b1);
      check("fetch_wait", ioctl_wait, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_din", ioctl_din, 8'h00);
      check("mid_rst_wait", ioctl_wait, 1'b0);
      check("mid_rst_req", sdr_req, 1'b0);
      check("mid_rst_addr", sdr_addr, 24'h0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_err", err, 1'b0);
      m_valid = 1'b0;
      m_din   = 8'h00;
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check("sync_req", sdr_req, 1'b1);
      resp_enable = 1'b1;
      @(negedge clk_sys);
      do_read(25'h40);
      check("post_sync_req", sdr_req, 1'b0);

`ifdef UPLOAD_TIMEOUT_EN
      // Ack withheld: timeout returns 0xFF and latches err; a late ack is ignored
      resp_enable = 1'b0;
      do_read(25'h50, -1, 1'b1);
      check("tmo_err", err, 1'b1);
      late_ack_cnt++;
      repeat (3) @(negedge clk_sys);
      check("late_din", ioctl_din, 8'hFF);
      check("late_wait", ioctl_wait, 1'b0);
      check("late_busy", busy, 1'b0);
      check("late_err", err, 1'b1);
`else
      check("err_tied", err, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
